// File: rtl/chan_priority_arbiter_if.sv
// chan_priority_arbiter_if: request / grant bundle of the channel priority arbiter.
//   req       requester -> arbiter  per-channel request lines (bit 0 highest priority)
//   en_mask   requester -> arbiter  per-channel enable, 1 = may be granted
//   gnt_ready consumer  -> arbiter  grant accepted when high together with gnt_valid
//   gnt_valid arbiter   -> consumer gnt_chan holds a valid channel number
//   gnt_chan  arbiter   -> consumer granted channel number
//   pending   arbiter   -> observer raw (unmasked) pending register
//   any_pend  arbiter   -> observer some enabled channel is pending
// master = the side driving requests / ready, slave = the arbiter.
interface chan_priority_arbiter_if #(
    parameter int NUM_CHAN = 9,
    parameter int CHAN_W   = 4
);
    logic [NUM_CHAN-1:0] req;
    logic [NUM_CHAN-1:0] en_mask;
    logic                gnt_valid;
    logic                gnt_ready;
    logic [CHAN_W-1:0]   gnt_chan;
    logic [NUM_CHAN-1:0] pending;
    logic                any_pend;

    modport master (
        output req, en_mask, gnt_ready,
        input  gnt_valid, gnt_chan, pending, any_pend
    );

    modport slave (
        input  req, en_mask, gnt_ready,
        output gnt_valid, gnt_chan, pending, any_pend
    );
endinterface

// File: rtl/chan_priority_arbiter.sv
// chan_priority_arbiter: captures per-channel requests into a pending register,
// picks the lowest-index enabled pending channel and offers it on a valid/ready
// grant port. The served pending bit is cleared on handshake.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  chan_priority_arbiter_if.slave (req, en_mask, gnt_ready in;
//        gnt_valid, gnt_chan, pending, any_pend out)
// The interface instance must be built with the same NUM_CHAN / CHAN_W as this
// module, and 2**CHAN_W >= NUM_CHAN.

// One pending bit plus its request-history flop.
module chan_pend_cell #(
    parameter int EDGE_MODE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic clr,
    output logic pend
);
    logic req_q;
    logic set;

    // Edge mode only latches a 0->1 transition; level mode sets every cycle req is high.
    assign set = (EDGE_MODE != 0) ? (req & ~req_q) : req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= 1'b0;
            pend  <= 1'b0;
        end else begin
            req_q <= req;
            // set has priority so a new event landing on the clearing edge is not lost
            pend  <= set | (pend & ~clr);
        end
    end
endmodule

module chan_priority_arbiter #(
    parameter int NUM_CHAN  = 9,
    parameter int CHAN_W    = 4,
    parameter int EDGE_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    chan_priority_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state;
    logic                gnt_valid;
    logic [CHAN_W-1:0]   gnt_chan;
    logic [NUM_CHAN-1:0] pend;
    logic [NUM_CHAN-1:0] clr;
    logic [NUM_CHAN-1:0] elig;
    logic [CHAN_W-1:0]   sel;
    logic                hs;

    assign hs   = gnt_valid & bus.gnt_ready;
    assign elig = pend & bus.en_mask;

    genvar i;
    generate
        for (i = 0; i < NUM_CHAN; i++) begin : g_chan
            assign clr[i] = hs & (gnt_chan == CHAN_W'(i));
            chan_pend_cell #(.EDGE_MODE(EDGE_MODE)) u_cell (
                .clk  (clk),
                .rst  (rst),
                .req  (bus.req[i]),
                .clr  (clr[i]),
                .pend (pend[i])
            );
        end
    endgenerate

    // Lowest set index wins: scan downward so the last hit is the smallest.
    always_comb begin
        sel = '0;
        for (int k = NUM_CHAN - 1; k >= 0; k--) begin
            if (elig[k]) sel = CHAN_W'(k);
        end
    end

    // Selection happens only in IDLE, so an accepted grant always leaves one idle
    // cycle and a grant in flight is never replaced by a higher-priority arrival.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            gnt_chan  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|elig) begin
                        gnt_chan  <= sel;
                        gnt_valid <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (bus.gnt_ready) begin
                        gnt_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    gnt_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt_valid = gnt_valid;
    assign bus.gnt_chan  = gnt_chan;
    assign bus.pending   = pend;
    assign bus.any_pend  = |elig;
endmodule

// File: tb/tb_chan_priority_arbiter.sv
module tb_chan_priority_arbiter;
    localparam int N = 9;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] en_mask = '0;
    logic ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chan_priority_arbiter_if #(.NUM_CHAN(N), .CHAN_W(W)) lvl_if ();
    chan_priority_arbiter_if #(.NUM_CHAN(N), .CHAN_W(W)) edg_if ();

    assign lvl_if.req = req;  assign lvl_if.en_mask = en_mask;  assign lvl_if.gnt_ready = ready;
    assign edg_if.req = req;  assign edg_if.en_mask = en_mask;  assign edg_if.gnt_ready = ready;

    chan_priority_arbiter #(.NUM_CHAN(N), .CHAN_W(W), .EDGE_MODE(0)) u_lvl (
        .clk(clk), .rst(rst), .bus(lvl_if.slave));
    chan_priority_arbiter #(.NUM_CHAN(N), .CHAN_W(W), .EDGE_MODE(1)) u_edg (
        .clk(clk), .rst(rst), .bus(edg_if.slave));

    // Reference model, index 0 = level mode, 1 = edge mode.
    bit [N-1:0] m_pend [2];
    bit [N-1:0] m_prev [2];
    bit         m_busy [2];
    int         m_chan [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = '0; m_prev[m] = '0; m_busy[m] = 0; m_chan[m] = 0;
        end
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            bit accepted;
            bit [N-1:0] nxt;
            accepted = m_busy[m] && ready;
            for (int i = 0; i < N; i++) begin
                bit event_in;
                event_in = (m == 1) ? (req[i] && !m_prev[m][i]) : req[i];
                nxt[i] = event_in || (m_pend[m][i] && !(accepted && m_chan[m] == i));
            end
            if (!m_busy[m]) begin
                bit found;
                found = 0;
                for (int i = 0; i < N; i++) begin
                    if (!found && m_pend[m][i] && en_mask[i]) begin
                        found = 1; m_busy[m] = 1; m_chan[m] = i;
                    end
                end
            end else if (accepted) begin
                m_busy[m] = 0;
            end
            m_pend[m] = nxt;
            m_prev[m] = req;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input int cyc);
        string s;
        s = $sformatf("cyc%0d", cyc);
        check({"lvl_valid_", s}, int'(lvl_if.gnt_valid), int'(m_busy[0]));
        check({"lvl_chan_",  s}, int'(lvl_if.gnt_chan),  m_chan[0]);
        check({"lvl_pend_",  s}, int'(lvl_if.pending),   int'(m_pend[0]));
        check({"lvl_any_",   s}, int'(lvl_if.any_pend),  int'(|(m_pend[0] & en_mask)));
        check({"edg_valid_", s}, int'(edg_if.gnt_valid), int'(m_busy[1]));
        check({"edg_chan_",  s}, int'(edg_if.gnt_chan),  m_chan[1]);
        check({"edg_pend_",  s}, int'(edg_if.pending),   int'(m_pend[1]));
        check({"edg_any_",   s}, int'(edg_if.any_pend),  int'(|(m_pend[1] & en_mask)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; ready = 1'b0; en_mask = '1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] mask;
        logic         ready;
        logic         exp_valid;
        int           exp_chan;
        logic [N-1:0] exp_pend;
        logic         exp_any;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int cnt;
        int cnt2;

        // priority sweep, then mask / unmask on the level instance
        vecs.push_back('{9'h150, 9'h1FF, 1, 0, 0, 9'h150, 1});
        vecs.push_back('{9'h000, 9'h1FF, 1, 1, 4, 9'h150, 1});
        vecs.push_back('{9'h000, 9'h1FF, 1, 0, 4, 9'h140, 1});
        vecs.push_back('{9'h000, 9'h1FF, 1, 1, 6, 9'h140, 1});
        vecs.push_back('{9'h000, 9'h1FF, 1, 0, 6, 9'h100, 1});
        vecs.push_back('{9'h000, 9'h1FF, 1, 1, 8, 9'h100, 1});
        vecs.push_back('{9'h000, 9'h1FF, 1, 0, 8, 9'h000, 0});
        vecs.push_back('{9'h000, 9'h1FF, 1, 0, 8, 9'h000, 0});
        vecs.push_back('{9'h003, 9'h1FE, 1, 0, 8, 9'h003, 1});
        vecs.push_back('{9'h000, 9'h1FE, 1, 1, 1, 9'h003, 1});
        vecs.push_back('{9'h000, 9'h1FE, 1, 0, 1, 9'h001, 0});
        vecs.push_back('{9'h000, 9'h1FE, 1, 0, 1, 9'h001, 0});
        vecs.push_back('{9'h000, 9'h1FF, 1, 1, 0, 9'h001, 1});
        vecs.push_back('{9'h000, 9'h1FF, 1, 0, 0, 9'h000, 0});

        do_reset();
        check("reset_valid", int'(lvl_if.gnt_valid), 0);
        check("reset_chan",  int'(lvl_if.gnt_chan),  0);
        check("reset_pend",  int'(lvl_if.pending),   0);
        check("reset_any",   int'(lvl_if.any_pend),  0);

        foreach (vecs[k]) begin
            req = vecs[k].req; en_mask = vecs[k].mask; ready = vecs[k].ready;
            tick();
            check($sformatf("vec%0d_valid", k), int'(lvl_if.gnt_valid), int'(vecs[k].exp_valid));
            check($sformatf("vec%0d_chan", k),  int'(lvl_if.gnt_chan),  vecs[k].exp_chan);
            check($sformatf("vec%0d_pend", k),  int'(lvl_if.pending),   int'(vecs[k].exp_pend));
            check($sformatf("vec%0d_any", k),   int'(lvl_if.any_pend),  int'(vecs[k].exp_any));
        end

        // async reset while channel 3 is granted
        do_reset();
        req = 9'h008; tick();
        req = '0; tick();
        check("pre_rst_valid", int'(lvl_if.gnt_valid), 1);
        check("pre_rst_chan",  int'(lvl_if.gnt_chan),  3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", int'(lvl_if.gnt_valid), 0);
        check("async_rst_pend",  int'(lvl_if.pending),   0);
        check("async_rst_chan",  int'(lvl_if.gnt_chan),  0);
        do_reset();

        // backpressure: chan 2 held while chan 0 arrives
        req = 9'h004; tick();
        req = '0; tick();
        req = 9'h001;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("bp_valid%0d", c), int'(lvl_if.gnt_valid), 1);
            check($sformatf("bp_chan%0d", c),  int'(lvl_if.gnt_chan),  2);
        end
        req = '0; ready = 1'b1; tick();
        check("bp_accept_valid", int'(lvl_if.gnt_valid), 0);
        check("bp_accept_pend",  int'(lvl_if.pending),   9'h001);
        tick();
        check("bp_next_valid", int'(lvl_if.gnt_valid), 1);
        check("bp_next_chan",  int'(lvl_if.gnt_chan),  0);

        // edge mode: held request yields exactly one grant
        do_reset();
        ready = 1'b1; req = 9'h020; cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (edg_if.gnt_valid) begin
                cnt++;
                check("edge_chan", int'(edg_if.gnt_chan), 5);
            end
        end
        check("edge_grant_count", cnt, 1);

        // edge mode: new rising edge on the clearing edge keeps the bit pending
        do_reset();
        req = 9'h020; tick();
        req = '0; tick();
        ready = 1'b0; tick();
        check("edge_sc_valid", int'(edg_if.gnt_valid), 1);
        req = 9'h020; ready = 1'b1; tick();
        check("edge_sc_pend",  int'(edg_if.pending),   9'h020);
        check("edge_sc_idle",  int'(edg_if.gnt_valid), 0);
        tick();
        check("edge_sc_regrant", int'(edg_if.gnt_valid), 1);
        tick();
        check("edge_sc_cleared", int'(edg_if.pending), 0);

        // level mode: held request regranted every 2 clocks, stops once dropped
        do_reset();
        ready = 1'b1; req = 9'h080; cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (lvl_if.gnt_valid) begin
                cnt++;
                check("level_chan", int'(lvl_if.gnt_chan), 7);
            end
        end
        check("level_grant_count", cnt, 5);
        req = '0; tick();
        check("level_drop_pend",  int'(lvl_if.pending),   0);
        check("level_drop_valid", int'(lvl_if.gnt_valid), 0);
        cnt2 = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (lvl_if.gnt_valid) cnt2++;
        end
        check("level_no_more_grants", cnt2, 0);

        // randomized traffic against the model on both instances
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req     = N'($urandom & $urandom & $urandom);
            en_mask = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            ready   = ($urandom_range(0, 2) != 0);
            tick();
            check_model(c);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
